// File: rtl/sos_detector.sv
// sos_detector: Morse receiver for the SOS link.
// Measures high/low run lengths on dataIn, classifies marks as dot/dash,
// groups them into letters, and strobes sos on an S, O, S letter sequence.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no letter pending; waiting for the first mark
// MARK  | counting a high run
// SPACE | letter pending; low run shorter than the letter gap so far
// LGAP  | letter emitted; a long enough low run here clears the history
module sos_detector #(
  parameter int DOT_MAX  = 2,
  parameter int DASH_MAX = 4,
  parameter int LGAP_MIN = 2,
  parameter int WORD_GAP = 6,
  parameter int RUN_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dataIn,
  output logic       dot,
  output logic       dash,
  output logic       err,
  output logic       letterValid,
  output logic [1:0] letter,
  output logic       sos
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

  localparam logic [1:0] CODE_X = 2'b00;
  localparam logic [1:0] CODE_S = 2'b01;
  localparam logic [1:0] CODE_O = 2'b10;

  localparam logic [RUN_W-1:0] DOT_MAX_C  = RUN_W'(DOT_MAX);
  localparam logic [RUN_W-1:0] DASH_MAX_C = RUN_W'(DASH_MAX);
  localparam logic [RUN_W-1:0] LGAP_MIN_C = RUN_W'(LGAP_MIN);
  localparam logic [RUN_W-1:0] WORD_GAP_C = RUN_W'(WORD_GAP);

  state_t state, state_nxt;

  logic             prev;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] cur_len;

  // symbol accumulator: up to three symbols (1 = dash) plus a bad flag
  logic [1:0] sym_cnt, cnt_nxt;
  logic [2:0] syms, syms_nxt;
  logic       bad, bad_nxt;

  // the two older entries of the letter window; the newest is the code
  // being decoded in the same cycle
  logic [1:0] hist_old, hist_old_nxt;
  logic [1:0] hist_new, hist_new_nxt;

  logic       emit;
  logic [1:0] code;
  logic       dot_nxt, dash_nxt, err_nxt, lv_nxt, sos_nxt;
  logic [1:0] letter_nxt;

  // length of the current run including this sample, saturating
  always_comb begin
    if (dataIn != prev)
      cur_len = RUN_W'(1);
    else if (&run_cnt)
      cur_len = run_cnt;
    else
      cur_len = run_cnt + 1'b1;
  end

  // run-length counter and previous-level register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= 1'b0;
      run_cnt <= '0;
    end else begin
      prev    <= dataIn;
      run_cnt <= cur_len;
    end
  end

  // next state, symbol accumulation, letter decode and history update
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = sym_cnt;
    syms_nxt     = syms;
    bad_nxt      = bad;
    hist_old_nxt = hist_old;
    hist_new_nxt = hist_new;
    dot_nxt      = 1'b0;
    dash_nxt     = 1'b0;
    err_nxt      = 1'b0;
    lv_nxt       = 1'b0;
    sos_nxt      = 1'b0;
    letter_nxt   = letter;
    emit         = 1'b0;
    code         = CODE_X;

    case (state)
      IDLE: begin
        if (dataIn) state_nxt = MARK;
      end
      MARK: begin
        if (!dataIn) begin
          state_nxt = SPACE;
          // the completed mark length is the registered run count
          if (run_cnt > DASH_MAX_C) begin
            err_nxt = 1'b1;
            bad_nxt = 1'b1;
          end else begin
            dot_nxt  = (run_cnt <= DOT_MAX_C);
            dash_nxt = !dot_nxt;
            case (sym_cnt)
              2'd0:    syms_nxt[0] = dash_nxt;
              2'd1:    syms_nxt[1] = dash_nxt;
              2'd2:    syms_nxt[2] = dash_nxt;
              default: bad_nxt     = 1'b1;
            endcase
            if (sym_cnt != 2'd3) cnt_nxt = sym_cnt + 2'd1;
          end
          if (cur_len == LGAP_MIN_C) begin
            emit      = 1'b1;
            state_nxt = LGAP;
          end
        end
      end
      SPACE: begin
        if (dataIn) begin
          state_nxt = MARK;
        end else if (cur_len == LGAP_MIN_C) begin
          emit      = 1'b1;
          state_nxt = LGAP;
        end
      end
      LGAP: begin
        if (dataIn) begin
          state_nxt = MARK;
        end else if (cur_len == WORD_GAP_C) begin
          hist_old_nxt = CODE_X;
          hist_new_nxt = CODE_X;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (emit) begin
      if (!bad_nxt && cnt_nxt == 2'd3 && syms_nxt == 3'b000)
        code = CODE_S;
      else if (!bad_nxt && cnt_nxt == 2'd3 && syms_nxt == 3'b111)
        code = CODE_O;
      lv_nxt       = 1'b1;
      letter_nxt   = code;
      sos_nxt      = (hist_old == CODE_S) && (hist_new == CODE_O) && (code == CODE_S);
      hist_old_nxt = hist_new;
      hist_new_nxt = code;
      cnt_nxt      = 2'd0;
      syms_nxt     = 3'b000;
      bad_nxt      = 1'b0;
    end
  end

  // state, accumulator, history and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sym_cnt     <= 2'd0;
      syms        <= 3'b000;
      bad         <= 1'b0;
      hist_old    <= CODE_X;
      hist_new    <= CODE_X;
      dot         <= 1'b0;
      dash        <= 1'b0;
      err         <= 1'b0;
      letterValid <= 1'b0;
      letter      <= CODE_X;
      sos         <= 1'b0;
    end else begin
      state       <= state_nxt;
      sym_cnt     <= cnt_nxt;
      syms        <= syms_nxt;
      bad         <= bad_nxt;
      hist_old    <= hist_old_nxt;
      hist_new    <= hist_new_nxt;
      dot         <= dot_nxt;
      dash        <= dash_nxt;
      err         <= err_nxt;
      letterValid <= lv_nxt;
      letter      <= letter_nxt;
      sos         <= sos_nxt;
    end
  end

endmodule

// File: tb/tb_sos_detector.sv
// Bench for sos_detector: stimulus is built as marks and gaps, and the
// expected strobes are derived from the mark/gap lengths directly.
module tb_sos_detector;

  localparam int DOT_MAX  = 2;
  localparam int DASH_MAX = 4;
  localparam int LGAP_MIN = 2;
  localparam int WORD_GAP = 6;
  localparam int RUN_W    = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       dataIn;
  logic       dot, dash, err, letterValid, sos;
  logic [1:0] letter;

  int n_checks = 0;
  int n_pass   = 0;

  // per-sample stimulus and expected strobes {sos, lv, err, dash, dot}
  bit         stim[$];
  logic [4:0] ev[$];
  logic [1:0] evl[$];
  // model context: symbols of the open letter (0 dot, 1 dash, 2 err), letter history
  int         syms[$];
  logic [1:0] hist[$];
  int         pend_len;
  logic [1:0] exp_letter;

  always #5 clk = ~clk;

  sos_detector #(
    .DOT_MAX(DOT_MAX), .DASH_MAX(DASH_MAX), .LGAP_MIN(LGAP_MIN),
    .WORD_GAP(WORD_GAP), .RUN_W(RUN_W)
  ) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn),
    .dot(dot), .dash(dash), .err(err), .letterValid(letterValid),
    .letter(letter), .sos(sos)
  );

  task automatic model_clear();
    stim.delete(); ev.delete(); evl.delete();
    syms.delete(); hist.delete();
    pend_len   = 0;
    exp_letter = 2'b00;
  endtask

  function automatic logic [1:0] decode();
    int nd = 0, nda = 0;
    foreach (syms[i]) begin
      if (syms[i] == 0) nd++;
      if (syms[i] == 1) nda++;
    end
    if (syms.size() == 3 && nd == 3) return 2'b01;
    if (syms.size() == 3 && nda == 3) return 2'b10;
    return 2'b00;
  endfunction

  task automatic add_low(input int n);
    for (int i = 0; i < n; i++) begin
      stim.push_back(1'b0); ev.push_back(5'b0); evl.push_back(2'b00);
    end
  endtask

  task automatic add_mark(input int len);
    for (int i = 0; i < len; i++) begin
      stim.push_back(1'b1); ev.push_back(5'b0); evl.push_back(2'b00);
    end
    pend_len = len;
  endtask

  // low run of g samples closing the pending mark
  task automatic add_gap(input int g);
    int e, k;
    logic [4:0] t;
    logic [1:0] c;
    e = stim.size();
    add_low(g);
    t = ev[e];
    if (pend_len <= DOT_MAX) begin t[0] = 1'b1; syms.push_back(0); end
    else if (pend_len <= DASH_MAX) begin t[1] = 1'b1; syms.push_back(1); end
    else begin t[2] = 1'b1; syms.push_back(2); end
    ev[e] = t;
    if (g >= LGAP_MIN) begin
      k = e + LGAP_MIN - 1;
      c = decode();
      t = ev[k];
      t[3] = 1'b1;
      if (c == 2'b01 && hist.size() >= 2 && hist[hist.size()-1] == 2'b10 &&
          hist[hist.size()-2] == 2'b01)
        t[4] = 1'b1;
      ev[k]  = t;
      evl[k] = c;
      hist.push_back(c);
      syms.delete();
    end
    if (g >= WORD_GAP) hist.delete();
  endtask

  task automatic send_s(input int gap);
    for (int i = 0; i < 3; i++) begin add_mark(1); add_gap(i == 2 ? gap : 1); end
  endtask

  task automatic send_o(input int gap);
    for (int i = 0; i < 3; i++) begin add_mark(3); add_gap(i == 2 ? gap : 1); end
  endtask

  task automatic send_letter(input int lens[$], input int gap);
    for (int i = 0; i < lens.size(); i++) begin
      add_mark(lens[i]);
      add_gap(i == lens.size() - 1 ? gap : 1);
    end
  endtask

  task automatic run_stream(input string name);
    logic [4:0] got;
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      dataIn = stim[i];
      @(posedge clk);
      #1;
      if (ev[i][3]) exp_letter = evl[i];
      got = {sos, letterValid, err, dash, dot};
      n_checks++;
      if (got !== ev[i])
        $display("FAIL %s strobes cycle %0d: got sos/lv/err/dash/dot=%b want %b", name, i, got, ev[i]);
      else n_pass++;
      n_checks++;
      if (letter !== exp_letter)
        $display("FAIL %s letter cycle %0d: got %b want %b", name, i, letter, exp_letter);
      else n_pass++;
    end
    stim.delete(); ev.delete(); evl.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    dataIn = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({sos, letterValid, err, dash, dot, letter} !== 7'b0)
      $display("FAIL %s: got sos/lv/err/dash/dot/letter=%b want 0000000", name,
               {sos, letterValid, err, dash, dot, letter});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    dataIn = 1'b0;
    #1;
    check_zero("reset_initial");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dataIn = (i % 3 != 2);
      @(posedge clk);
      #1;
      check_zero("reset_held");
    end
    do_reset();
  endtask

  task automatic test_driver_sos();
    do_reset();
    add_low(2);
    send_s(3); send_o(3); send_s(3);
    run_stream("driver_sos");
  endtask

  task automatic test_overlap();
    do_reset();
    add_low(1);
    send_s(LGAP_MIN); send_o(LGAP_MIN); send_s(LGAP_MIN); send_o(LGAP_MIN); send_s(LGAP_MIN);
    add_low(2);
    run_stream("overlap");
  endtask

  task automatic test_word_gap();
    do_reset();
    add_low(1);
    send_s(2); send_o(WORD_GAP); send_s(3);
    run_stream("word_gap");
  endtask

  task automatic test_malformed();
    int l[$];
    do_reset();
    add_low(1);
    l = {1, 3, 1};    send_letter(l, 3);
    send_s(2); send_o(2);
    l = {1, 1, 1, 1}; send_letter(l, 3);
    send_s(2); send_o(2);
    l = {7};          send_letter(l, 3);
    l = {1, 1, 1, 7}; send_letter(l, 3);
    run_stream("malformed");
  endtask

  task automatic test_boundaries();
    int l[$];
    do_reset();
    add_low(1);
    for (int len = 1; len <= 6; len++) begin
      l = {len}; send_letter(l, 2);
    end
    l = {2, 2, 2}; send_letter(l, 2);
    l = {4, 3, 4}; send_letter(l, 2);
    l = {40};      send_letter(l, 3);
    l = {1, 1};    send_letter(l, 1);
    l = {1};       send_letter(l, 2);
    run_stream("boundaries");
    // continuous high never strobes until it falls
    add_mark(45);
    add_gap(WORD_GAP);
    run_stream("long_high");
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_low(1);
    send_s(3);
    add_mark(1); add_gap(1); add_mark(1); add_gap(1);
    run_stream("reset_mid_pre");
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_async");
    @(negedge clk);
    model_clear();
    reset = 1'b0;
    add_low(1);
    send_o(2); send_s(3);
    run_stream("reset_mid_post");
  endtask

  task automatic test_random();
    int l[$];
    int kind, n, g;
    do_reset();
    add_low(2);
    for (int k = 0; k < 60; k++) begin
      g = ($urandom_range(0, 4) == 0) ? $urandom_range(WORD_GAP, WORD_GAP + 3)
                                      : $urandom_range(LGAP_MIN, WORD_GAP - 1);
      kind = $urandom_range(0, 4);
      if (kind <= 1) send_s(g);
      else if (kind == 2) send_o(g);
      else begin
        l.delete();
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++)
          l.push_back(($urandom_range(0, 15) == 0) ? 35 : $urandom_range(1, 6));
        send_letter(l, g);
      end
    end
    run_stream("random");
  endtask

  initial begin
    test_reset();
    test_driver_sos();
    test_overlap();
    test_word_gap();
    test_malformed();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
